// File: rtl/mux_rr_sched_if.sv
// Request/grant bundle between the 16 requesters and the round-robin mux scheduler.
// master = scheduler side (drives select/grant), slave = requester side.
interface mux_rr_sched_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;

  modport master (input req, done, output sel, grant, valid, timeout);
  modport slave  (output req, done, input sel, grant, valid, timeout);
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin owner of a shared 16:1 mux select; grant registered 1 edge after request.
// Grant held until done, request drop or MAX_HOLD cycles; a one-cycle idle gap follows every grant.
module mux_rr_sched #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_sched_if.master bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [7:0]      hold_q, hold_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic [SELW-1:0] winner;
  logic [SELW-1:0] idx;
  logic            found;
  logic            at_limit;

  // First requester at or after ptr, wrapping naturally in SELW bits.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + k[SELW-1:0];
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    at_limit  = (hold_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
          valid_d = 1'b1;
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        if (bus.done || !bus.req[sel_q] || at_limit) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          grant_d   = '0;
          ptr_d     = sel_q + SELW'(1);
          hold_d    = 8'd0;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = at_limit && !bus.done && bus.req[sel_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      hold_q    <= 8'd0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
Round-robin scheduler that shares one 16-to-1 mux between 16 requesters. It arbitrates the request lines and drives the 4-bit mux select. It holds each grant until the owner releases it, the owner drops its request, or a hold-time limit expires. It sits directly in front of the existing 16:1 mux and owns its select input.

Parameters:
N, 16, number of requesters (fixed at 16; matches mux width)
SELW, 4, select width, log2(N)
MAX_HOLD, 8, maximum grant length in cycles before forced release; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  16  request vector; bit i = requester i wants the mux
done  input  1  current owner releases grant (sampled only in GRANT)
sel  output  4  mux select; index of current/last grantee
grant  output  16  one-hot grant; grant[sel]=1 while valid
valid  output  1  grant active; mux output belongs to grantee
timeout  output  1  one-cycle pulse: last grant was force-released by hold limit

Behaviour:
- Reset is asynchronous and active-high. While rst=1, outputs are forced immediately: sel=0, grant=0, valid=0, timeout=0. Internal state: state=IDLE, ptr=0, hold_cnt=0.
- Reset mid-grant aborts the grant immediately. No timeout pulse is generated.
- All outputs are registered; there is no combinational path from inputs to outputs.
- State IDLE:
  - If req==0, stay in IDLE. valid=0, grant=0, sel holds its last value so the mux input stays stable.
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod 16.
  - At the next edge: state=GRANT, sel=winner, grant=1<<winner, valid=1, hold_cnt=0.
  - Latency from req sampled to valid high is 1 edge.
- State GRANT:
  - hold_cnt increments at each edge while in GRANT; 8-bit, never wraps because release occurs first.
  - Release conditions, evaluated each cycle, priority order:
    (a) done=1
    (b) req[sel]=0
    (c) hold_cnt==MAX_HOLD-1
  - On release, at the next edge: state=IDLE, valid=0, grant=0, ptr=sel+1 mod 16 (15 wraps to 0), hold_cnt=0.
  - timeout=1 for exactly the first IDLE cycle, and only if (c) was the sole cause. If done=1 or req[sel]=0 in the same cycle as (c), there is no timeout.
  - valid stays high for at most MAX_HOLD cycles per grant.
- Every grant is followed by at least one IDLE cycle with valid=0 (mux settle gap). Re-arbitration happens on the edge that ends that IDLE cycle.
- Fairness: the just-served requester has lowest priority next round. With all 16 requesting continuously, grants cycle 0,1,...,15,0.
- Request changes on other lines during GRANT do not affect the current grant.
- done asserted in IDLE is ignored.
- sel never changes while valid=1.

Test Plan:
1. Reset: hold rst=1, then release with req=0 -> sel=0, grant=0, valid=0, timeout=0; assert rst asynchronously mid-grant -> outputs clear before the next clk edge.
2. Priority/rotation: after reset, req=16'h1001 held -> grant 0x0001 (sel=0) one edge later; pulse done -> one IDLE cycle, then sel=12, grant=0x1000.
3. Wrap: owner sel=15 releases with req=16'h8001 -> next grant sel=0 (ptr wrapped 15->0), not 15.
4. Timeout: MAX_HOLD=8, req=16'h0010 held, done=0 -> valid high exactly 8 cycles at sel=4; timeout=1 in the following IDLE cycle only; sel=4 re-granted one cycle later.
5. Drop: during grant to sel=3, deassert req[3] after 2 cycles -> valid falls at the next edge, timeout stays 0, ptr=4.
6. Coincident: done=1 in the same cycle as hold_cnt==MAX_HOLD-1 -> release with timeout=0. Full load: req=16'hFFFF -> grant order 0..15,0 with one idle cycle between each grant.
